pipe_fetch_queue: RTL and testbench
===================================

PIPE_FETCH_QUEUE -- requirements
Module: pipe_fetch_queue

Interface
REQ-001 Parameter PROGRAM_COUNTER_RESET, default 32'h0000_0000: fetch program counter value after reset.
REQ-002 Parameter QUEUE_DEPTH, default 2: instruction queue entries, power of two, range 2..16.
REQ-003 Single clock clk; reset is asynchronous and active-low.
REQ-004 Port clk  in  1  clock, all state on rising edge.
REQ-005 Port rst_n  in  1  asynchronous active-low reset.
REQ-006 Port run  in  1  enables fetching.
REQ-007 Port flush  in  1  redirect request; clears queue, loads new PC.
REQ-008 Port flushProgramCounter  in  32  PC loaded on flush.
REQ-009 Port consume  in  1  decode takes head entry.
REQ-010 Port instruction  out  32  head instruction; 32'hFFFF_FFFF when no valid entry.
REQ-011 Port instructionProgramCounter  out  32  PC of head instruction; 0 when no valid entry.
REQ-012 Port instructionValid  out  1  head entry valid.
REQ-013 Port queueCount  out  $clog2(QUEUE_DEPTH)+1  occupied entries.
REQ-014 Port addressMisaligned  out  1  fetch PC bits [1:0] nonzero.
REQ-015 Port fetchAddress  out  32  equals fetch PC.
REQ-016 Port fetchEnable  out  1  fetch request.
REQ-017 Port fetchBusy  in  1  memory not ready; fetch completes in a cycle with fetchEnable=1, fetchBusy=0.
REQ-018 Port fetchData  in  32  instruction word, valid in the completing cycle.

Function
REQ-019 fetchEnable SHALL be run && !flush && !addressMisaligned && queueCount<QUEUE_DEPTH, combinational.
REQ-020 On a completing fetch, {fetchAddress, fetchData} SHALL be written at tail on the next edge and fetch PC SHALL advance by 4, wrapping modulo 2^32.
REQ-021 Pop SHALL occur when consume && instructionValid; consume with instructionValid=0 SHALL be ignored.
REQ-022 Simultaneous push and pop SHALL leave queueCount unchanged; full queue SHALL not fetch even if consume=1 that cycle.
REQ-023 Head/tail pointers SHALL wrap modulo QUEUE_DEPTH; queue order SHALL be strict FIFO.
REQ-024 Fetch-to-instructionValid latency SHALL be 1 cycle into an empty queue (without REQ-032 bypass).
REQ-025 flush SHALL take priority over push, pop and consume: next edge empties queue, queueCount=0, fetch PC=flushProgramCounter.
REQ-026 Misaligned fetch PC SHALL hold addressMisaligned=1 and suppress fetchEnable until a flush loads an aligned PC; queued entries SHALL still drain.
REQ-027 run=0 SHALL stop new fetches only; queue contents and consume SHALL remain operational.
REQ-028 fetchBusy=1 SHALL hold fetch PC and queue tail unchanged.

Reset
REQ-029 rst_n=0 SHALL asynchronously set fetch PC=PROGRAM_COUNTER_RESET, pointers=0, queueCount=0, instructionValid=0, instruction=32'hFFFF_FFFF, instructionProgramCounter=0.
REQ-030 fetchEnable SHALL be 0 while rst_n=0.
REQ-031 Reset asserted mid-fetch SHALL discard the in-flight word; first request after release SHALL be at PROGRAM_COUNTER_RESET.

Configuration
REQ-032 Macro PIPE_FETCH_BYPASS_EN defined: with queue empty and a completing fetch, instruction/instructionProgramCounter SHALL present fetchData/fetchAddress combinationally with instructionValid=1; if consume=1 that cycle the word SHALL not be written to the queue.
REQ-033 PIPE_FETCH_BYPASS_EN undefined: no combinational path from fetchData to outputs; REQ-024 latency applies.

Verification
REQ-034 Reset release, run=1, fetchBusy=0, consume=0, QUEUE_DEPTH=2 -> fetches at 0x0,0x4; queueCount=2; fetchEnable=0; head PC 0x0.
REQ-035 Full queue, consume=1 every cycle, fetchBusy=0 -> one pop then alternating fetch/pop; instructions delivered in PC order 0x0,0x4,0x8 with no gaps beyond one cycle.
REQ-036 Queue holding 2 entries, flush=1, flushProgramCounter=0x100, consume=1 -> next cycle queueCount=0, no pop counted, next fetchAddress=0x100.
REQ-037 flush to 0x102 -> addressMisaligned=1, fetchEnable=0 indefinitely; flush to 0x200 -> addressMisaligned=0, fetch resumes at 0x200.
REQ-038 fetchBusy=1 for 3 cycles at PC 0x8 -> fetchAddress held 0x8, queueCount unchanged; completion then pushes PC 0x8.
REQ-039 With PIPE_FETCH_BYPASS_EN, empty queue, completing fetch of 0x0000_0013 with consume=1 -> instructionValid=1 same cycle, instruction=0x0000_0013, queueCount stays 0; without macro, valid appears next cycle.

Source files
------------

// File: rtl/pipe_fetch_queue.sv
// Instruction fetch unit with a small FIFO of {pc, word} entries feeding decode.
// Define PIPE_FETCH_BYPASS_EN to forward a completing fetch straight to the head outputs when the queue is empty.
module pipe_fetch_queue #(
  parameter logic [31:0] PROGRAM_COUNTER_RESET = 32'h0000_0000,
  parameter int unsigned QUEUE_DEPTH           = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           run,
  input  logic                           flush,
  input  logic [31:0]                    flushProgramCounter,
  input  logic                           consume,
  output logic [31:0]                    instruction,
  output logic [31:0]                    instructionProgramCounter,
  output logic                           instructionValid,
  output logic [$clog2(QUEUE_DEPTH):0]   queueCount,
  output logic                           addressMisaligned,
  output logic [31:0]                    fetchAddress,
  output logic                           fetchEnable,
  input  logic                           fetchBusy,
  input  logic [31:0]                    fetchData
);

  localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(QUEUE_DEPTH);

  logic [31:0]      pc_q, pc_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [31:0] pc_mem   [QUEUE_DEPTH];
  logic [31:0] data_mem [QUEUE_DEPTH];

  logic queue_empty;
  logic queue_full;
  logic fetch_done;
  logic bypass_hit;
  logic push;
  logic pop;

  assign queue_empty       = (count_q == '0);
  assign queue_full        = (count_q >= DEPTH_CNT);
  assign addressMisaligned = |pc_q[1:0];
  assign fetchAddress      = pc_q;

  // rst_n is folded in so no request escapes while reset is held.
  assign fetchEnable = rst_n && run && !flush && !addressMisaligned && !queue_full;
  assign fetch_done  = fetchEnable && !fetchBusy;

`ifdef PIPE_FETCH_BYPASS_EN
  assign bypass_hit = fetch_done && queue_empty;
`else
  assign bypass_hit = 1'b0;
`endif

  // A bypassed word consumed in the same cycle never lands in the queue.
  assign push = fetch_done && !(bypass_hit && consume);
  assign pop  = consume && !queue_empty && !flush;

  always_comb begin
    pc_d    = pc_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      pc_d    = flushProgramCounter;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (fetch_done) begin
        pc_d = pc_q + 32'd4;
      end
      if (push) begin
        tail_d = tail_q + 1'b1;
      end
      if (pop) begin
        head_d = head_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= PROGRAM_COUNTER_RESET;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage carries no reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[tail_q]   <= pc_q;
      data_mem[tail_q] <= fetchData;
    end
  end

  always_comb begin
    instruction               = 32'hFFFF_FFFF;
    instructionProgramCounter = 32'h0000_0000;
    instructionValid          = 1'b0;
    if (!queue_empty) begin
      instruction               = data_mem[head_q];
      instructionProgramCounter = pc_mem[head_q];
      instructionValid          = 1'b1;
    end else if (bypass_hit) begin
      instruction               = fetchData;
      instructionProgramCounter = pc_q;
      instructionValid          = 1'b1;
    end
  end

  assign queueCount = count_q;

endmodule

// File: tb/tb_pipe_fetch_queue.sv
// Directed bench for pipe_fetch_queue (QUEUE_DEPTH=2, reset PC 0).
// Memory model returns fetchAddress + 0x1000_0013 as the instruction word.
module tb_pipe_fetch_queue;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic        flush;
  logic [31:0] flushProgramCounter;
  logic        consume;
  logic [31:0] instruction;
  logic [31:0] instructionProgramCounter;
  logic        instructionValid;
  logic [1:0]  queueCount;
  logic        addressMisaligned;
  logic [31:0] fetchAddress;
  logic        fetchEnable;
  logic        fetchBusy;
  logic [31:0] fetchData;

  int n_checks = 0;
  int n_pass   = 0;

  pipe_fetch_queue #(
    .PROGRAM_COUNTER_RESET(32'h0000_0000),
    .QUEUE_DEPTH(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .run(run),
    .flush(flush),
    .flushProgramCounter(flushProgramCounter),
    .consume(consume),
    .instruction(instruction),
    .instructionProgramCounter(instructionProgramCounter),
    .instructionValid(instructionValid),
    .queueCount(queueCount),
    .addressMisaligned(addressMisaligned),
    .fetchAddress(fetchAddress),
    .fetchEnable(fetchEnable),
    .fetchBusy(fetchBusy),
    .fetchData(fetchData)
  );

  assign fetchData = fetchAddress + 32'h1000_0013;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0;
    run = 1'b1;
    flush = 1'b0;
    flushProgramCounter = 32'h0;
    consume = 1'b0;
    fetchBusy = 1'b0;

    #2;
    chk("rst_en", 32'(fetchEnable), 32'h0);
    chk("rst_valid", 32'(instructionValid), 32'h0);
    chk("rst_instr", instruction, 32'hFFFF_FFFF);
    chk("rst_ipc", instructionProgramCounter, 32'h0);
    chk("rst_count", 32'(queueCount), 32'h0);
    chk("rst_addr", fetchAddress, 32'h0);

    #10 rst_n = 1'b1;
    #1;
    chk("rel_en", 32'(fetchEnable), 32'h1);
    chk("rel_valid", 32'(instructionValid), 32'h0);

    tick();
    chk("lat_count", 32'(queueCount), 32'h1);
    chk("lat_valid", 32'(instructionValid), 32'h1);
    chk("lat_instr", instruction, 32'h1000_0013);
    chk("lat_ipc", instructionProgramCounter, 32'h0);
    chk("lat_addr", fetchAddress, 32'h4);

    tick();
    chk("full_count", 32'(queueCount), 32'h2);
    chk("full_en", 32'(fetchEnable), 32'h0);
    chk("full_addr", fetchAddress, 32'h8);
    chk("full_ipc", instructionProgramCounter, 32'h0);

    tick();
    chk("hold_count", 32'(queueCount), 32'h2);
    consume = 1'b1;
    #1;
    chk("full_cons_en", 32'(fetchEnable), 32'h0);

    tick();
    chk("pop1_count", 32'(queueCount), 32'h1);
    chk("pop1_ipc", instructionProgramCounter, 32'h4);
    chk("pop1_en", 32'(fetchEnable), 32'h1);

    tick();
    chk("pop2_count", 32'(queueCount), 32'h1);
    chk("pop2_ipc", instructionProgramCounter, 32'h8);
    chk("pop2_instr", instruction, 32'h1000_001B);
    chk("pop2_addr", fetchAddress, 32'hC);
    consume = 1'b0;

    tick();
    chk("refill_count", 32'(queueCount), 32'h2);
    chk("refill_ipc", instructionProgramCounter, 32'h8);
    flush = 1'b1;
    flushProgramCounter = 32'h100;
    consume = 1'b1;
    #1;
    chk("flush_en", 32'(fetchEnable), 32'h0);

    tick();
    chk("flush_count", 32'(queueCount), 32'h0);
    chk("flush_valid", 32'(instructionValid), 32'h0);
    chk("flush_instr", instruction, 32'hFFFF_FFFF);
    chk("flush_addr", fetchAddress, 32'h100);
    flush = 1'b0;
    consume = 1'b0;

    tick();
    chk("f100_count", 32'(queueCount), 32'h1);
    chk("f100_ipc", instructionProgramCounter, 32'h100);
    chk("f100_instr", instruction, 32'h1000_0113);
    flush = 1'b1;
    flushProgramCounter = 32'h102;

    tick();
    flush = 1'b0;
    #1;
    chk("mis_flag", 32'(addressMisaligned), 32'h1);
    chk("mis_en", 32'(fetchEnable), 32'h0);
    chk("mis_addr", fetchAddress, 32'h102);
    tick();
    tick();
    chk("mis_flag2", 32'(addressMisaligned), 32'h1);
    chk("mis_en2", 32'(fetchEnable), 32'h0);
    chk("mis_count2", 32'(queueCount), 32'h0);
    flush = 1'b1;
    flushProgramCounter = 32'h200;

    tick();
    flush = 1'b0;
    #1;
    chk("al_flag", 32'(addressMisaligned), 32'h0);
    chk("al_en", 32'(fetchEnable), 32'h1);
    chk("al_addr", fetchAddress, 32'h200);

    tick();
    chk("f200_count", 32'(queueCount), 32'h1);
    chk("f200_ipc", instructionProgramCounter, 32'h200);
    flush = 1'b1;
    flushProgramCounter = 32'h8;

    tick();
    flush = 1'b0;
    fetchBusy = 1'b1;
    #1;
    chk("busy_en", 32'(fetchEnable), 32'h1);
    chk("busy_addr0", fetchAddress, 32'h8);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("busy_addr", fetchAddress, 32'h8);
      chk("busy_count", 32'(queueCount), 32'h0);
    end
    fetchBusy = 1'b0;

    tick();
    chk("busy_done_count", 32'(queueCount), 32'h1);
    chk("busy_done_ipc", instructionProgramCounter, 32'h8);
    chk("busy_done_instr", instruction, 32'h1000_001B);
    chk("busy_done_addr", fetchAddress, 32'hC);
    run = 1'b0;
    #1;
    chk("stop_en", 32'(fetchEnable), 32'h0);

    tick();
    chk("stop_count", 32'(queueCount), 32'h1);
    chk("stop_addr", fetchAddress, 32'hC);
    consume = 1'b1;

    tick();
    chk("drain_count", 32'(queueCount), 32'h0);
    chk("drain_valid", 32'(instructionValid), 32'h0);

    tick();
    chk("idle_cons_count", 32'(queueCount), 32'h0);
    run = 1'b1;
    #1;
`ifdef PIPE_FETCH_BYPASS_EN
    chk("byp_valid", 32'(instructionValid), 32'h1);
    chk("byp_instr", instruction, 32'h1000_001F);
    chk("byp_ipc", instructionProgramCounter, 32'hC);
`else
    chk("byp_valid", 32'(instructionValid), 32'h0);
    chk("byp_instr", instruction, 32'hFFFF_FFFF);
`endif

    tick();
    chk("byp_addr", fetchAddress, 32'h10);
`ifdef PIPE_FETCH_BYPASS_EN
    chk("byp_count", 32'(queueCount), 32'h0);
`else
    chk("byp_count", 32'(queueCount), 32'h1);
    chk("byp_ipc_next", instructionProgramCounter, 32'hC);
`endif
    consume = 1'b0;
    run = 1'b1;
    #1;
    chk("pre_rst_en", 32'(fetchEnable), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_en", 32'(fetchEnable), 32'h0);
    chk("mid_rst_addr", fetchAddress, 32'h0);
    chk("mid_rst_count", 32'(queueCount), 32'h0);
    chk("mid_rst_valid", 32'(instructionValid), 32'h0);

    tick();
    rst_n = 1'b1;
    #1;
    chk("post_rst_addr", fetchAddress, 32'h0);
    chk("post_rst_en", 32'(fetchEnable), 32'h1);

    tick();
    chk("post_rst_count", 32'(queueCount), 32'h1);
    chk("post_rst_ipc", instructionProgramCounter, 32'h0);
    chk("post_rst_addr4", fetchAddress, 32'h4);
    flush = 1'b1;
    flushProgramCounter = 32'hFFFF_FFFC;

    tick();
    flush = 1'b0;
    chk("wrap_count0", 32'(queueCount), 32'h0);
    chk("wrap_addr0", fetchAddress, 32'hFFFF_FFFC);

    tick();
    chk("wrap_count", 32'(queueCount), 32'h1);
    chk("wrap_ipc", instructionProgramCounter, 32'hFFFF_FFFC);
    chk("wrap_instr", instruction, 32'h1000_000F);
    chk("wrap_addr", fetchAddress, 32'h0);

    run = 1'b0;
    tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed no finish expected finish by 20000");
    $fatal(1, "timeout");
  end

endmodule
